// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: integer pixel-clock divider, x/y raster
// counters, pixel requests, frame/line markers and delay-matched sync/blank outputs.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   CLK_DIV    = 2,
  parameter int   PIPE_DELAY = 1,
  parameter int   X_W        = 10,
  parameter int   Y_W        = 10
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           en,
  output logic           pix_ce,
  output logic           pix_req,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           line_start,
  output logic           VGA_CLK,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D_W     = $clog2(CLK_DIV);

  localparam logic [D_W-1:0] D_LAST      = D_W'(CLK_DIV - 1);
  localparam logic [D_W-1:0] D_HALF      = D_W'(CLK_DIV / 2);
  localparam logic [X_W-1:0] X_LAST      = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] X_HS_FIRST  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] X_HS_LAST   = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST      = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_VS_FIRST  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] Y_VS_LAST   = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [D_W-1:0]        d_r;
  logic [D_W-1:0]        d_nxt_s;
  logic                  vga_clk_r;
  logic [X_W-1:0]        x_r;
  logic [X_W-1:0]        x_nxt_s;
  logic [Y_W-1:0]        y_r;
  logic [Y_W-1:0]        y_nxt_s;
  logic                  pix_ce_s;
  logic                  x_wrap_s;
  logic                  y_wrap_s;
  logic                  active_s;
  logic                  hs_lvl_s;
  logic                  vs_lvl_s;
  logic                  line_start_r;
  logic                  frame_start_r;
  logic [PIPE_DELAY-1:0] hs_dl_r;
  logic [PIPE_DELAY-1:0] vs_dl_r;
  logic [PIPE_DELAY-1:0] bl_dl_r;

  // Divider, raster next-state and raw sync/blank decode of the current (x,y)
  always_comb begin
    d_nxt_s  = d_r;
    x_nxt_s  = x_r;
    y_nxt_s  = y_r;
    pix_ce_s = 1'b0;
    x_wrap_s = (x_r == X_LAST);
    y_wrap_s = (y_r == Y_LAST);
    if (d_r == D_LAST) begin
      d_nxt_s  = {D_W{1'b0}};
      pix_ce_s = en;
    end else begin
      d_nxt_s  = d_r + 1'b1;
      pix_ce_s = 1'b0;
    end
    if (pix_ce_s) begin
      if (x_wrap_s) begin
        x_nxt_s = {X_W{1'b0}};
        if (y_wrap_s) begin
          y_nxt_s = {Y_W{1'b0}};
        end else begin
          y_nxt_s = y_r + 1'b1;
        end
      end else begin
        x_nxt_s = x_r + 1'b1;
        y_nxt_s = y_r;
      end
    end else begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
    end
    active_s = (x_r <= X_ACT_LAST) && (y_r <= Y_ACT_LAST);
    hs_lvl_s = ((x_r >= X_HS_FIRST) && (x_r <= X_HS_LAST)) ? HS_POL : ~HS_POL;
    vs_lvl_s = ((y_r >= Y_VS_FIRST) && (y_r <= Y_VS_LAST)) ? VS_POL : ~VS_POL;
  end

  // Divider, raster counters and frame/line markers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      d_r           <= {D_W{1'b0}};
      vga_clk_r     <= 1'b0;
      x_r           <= {X_W{1'b0}};
      y_r           <= {Y_W{1'b0}};
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      d_r           <= d_nxt_s;
      // VGA_CLK tracks the divider phase it will show next cycle, so it falls as x advances
      vga_clk_r     <= (d_nxt_s >= D_HALF);
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      line_start_r  <= pix_ce_s && x_wrap_s;
      frame_start_r <= pix_ce_s && x_wrap_s && y_wrap_s;
    end
  end

  // Sync/blank delay line, advanced once per pixel tick to match pixel-source latency
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hs_dl_r <= {PIPE_DELAY{~HS_POL}};
      vs_dl_r <= {PIPE_DELAY{~VS_POL}};
      bl_dl_r <= {PIPE_DELAY{1'b0}};
    end else if (pix_ce_s) begin
      hs_dl_r[0] <= hs_lvl_s;
      vs_dl_r[0] <= vs_lvl_s;
      bl_dl_r[0] <= active_s;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_dl_r[i] <= hs_dl_r[i-1];
        vs_dl_r[i] <= vs_dl_r[i-1];
        bl_dl_r[i] <= bl_dl_r[i-1];
      end
    end else begin
      hs_dl_r <= hs_dl_r;
      vs_dl_r <= vs_dl_r;
      bl_dl_r <= bl_dl_r;
    end
  end

  assign pix_ce      = pix_ce_s;
  assign pix_req     = pix_ce_s && active_s;
  assign x           = x_r;
  assign y           = y_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign VGA_CLK     = vga_clk_r;
  assign VGA_HS      = hs_dl_r[PIPE_DELAY-1];
  assign VGA_VS      = vs_dl_r[PIPE_DELAY-1];
  // Blanking must drop immediately when the raster is frozen
  assign VGA_BLANK_N = bl_dl_r[PIPE_DELAY-1] && en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen with a 16x8 raster; a second
// instance with a three-tick delay line checks output latency.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       pix_ce, pix_req, frame_start, line_start;
  logic [9:0] x, y;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N;
  logic       pix_ce2, pix_req2, frame_start2, line_start2;
  logic [9:0] x2, y2;
  logic       VGA_CLK2, VGA_HS2, VGA_VS2, VGA_BLANK_N2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_req = 0, cnt_hs = 0, cnt_vs = 0, cnt_bl = 0, cnt_bl2 = 0, cnt_ls = 0, cnt_fs = 0;
  int budget;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE_DELAY(1), .X_W(10), .Y_W(10)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .en(en), .pix_ce(pix_ce), .pix_req(pix_req),
    .x(x), .y(y), .frame_start(frame_start), .line_start(line_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE_DELAY(3), .X_W(10), .Y_W(10)
  ) dut3 (
    .CLOCK_50(clk), .reset(reset), .en(en), .pix_ce(pix_ce2), .pix_req(pix_req2),
    .x(x2), .y(y2), .frame_start(frame_start2), .line_start(line_start2),
    .VGA_CLK(VGA_CLK2), .VGA_HS(VGA_HS2), .VGA_VS(VGA_VS2), .VGA_BLANK_N(VGA_BLANK_N2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Expected raster state at cycle i after reset release (pixel p = i/2)
  task automatic model_check(input int i);
    int p, xp, yp, q, qx, qy;
    logic ehs, evs, ebl;
    p  = i / 2;
    xp = p % 16;
    yp = (p / 16) % 8;
    chk("x", x, xp);
    chk("y", y, yp);
    chk("vga_clk", VGA_CLK, i % 2);
    chk("pix_ce", pix_ce, i % 2);
    chk("pix_req", pix_req, (i % 2 == 1) && (xp < 8) && (yp < 4));
    chk("line_start", line_start, (i % 2 == 0) && (xp == 0));
    chk("frame_start", frame_start, (i % 2 == 0) && (xp == 0) && (yp == 0));
    ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
    if (p >= 1) begin
      q = p - 1; qx = q % 16; qy = (q / 16) % 8;
      ehs = !(qx >= 10 && qx <= 12);
      evs = (qy != 5);
      ebl = (qx < 8) && (qy < 4);
    end
    chk("hs_d1", VGA_HS, ehs);
    chk("vs_d1", VGA_VS, evs);
    chk("blank_d1", VGA_BLANK_N, ebl);
    ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
    if (p >= 3) begin
      q = p - 3; qx = q % 16; qy = (q / 16) % 8;
      ehs = !(qx >= 10 && qx <= 12);
      evs = (qy != 5);
      ebl = (qx < 8) && (qy < 4);
    end
    chk("hs_d3", VGA_HS2, ehs);
    chk("vs_d3", VGA_VS2, evs);
    chk("blank_d3", VGA_BLANK_N2, ebl);
  endtask

  initial begin
    // Reset held for three cycles
    reset = 1'b1;
    en    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_vga_clk", VGA_CLK, 0);
      chk("rst_pix_ce", pix_ce, 0);
      chk("rst_pix_req", pix_req, 0);
      chk("rst_line_start", line_start, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_hs", VGA_HS, 1);
      chk("rst_vs", VGA_VS, 1);
      chk("rst_blank", VGA_BLANK_N, 0);
      chk("rst_blank_d3", VGA_BLANK_N2, 0);
    end
    reset = 1'b0;
    cyc   = 0;

    // One full frame with alignment and marker checks
    for (int i = 1; i <= 256; i++) begin
      tick();
      model_check(cyc);
      if (cyc % 2 == 1) begin
        if (VGA_HS == 1'b0) cnt_hs++;
        if (VGA_VS == 1'b0) cnt_vs++;
        if (VGA_BLANK_N == 1'b1) cnt_bl++;
        if (VGA_BLANK_N2 == 1'b1) cnt_bl2++;
      end
      if (pix_req == 1'b1) cnt_req++;
      if (line_start == 1'b1) cnt_ls++;
      if (frame_start == 1'b1) cnt_fs++;
      if (cyc == 1) begin
        chk("first_req", pix_req, 1);
        chk("first_req_x", x, 0);
      end
      if (cyc == 21) chk("hs_before_sync", VGA_HS, 1);
      if (cyc == 23) chk("hs_first_low", VGA_HS, 0);
      if (cyc == 27) chk("hs_last_low", VGA_HS, 0);
      if (cyc == 29) chk("hs_after_sync", VGA_HS, 1);
      if (cyc == 32) begin
        chk("ls_line1", line_start, 1);
        chk("ls_line1_y", y, 1);
      end
      if (cyc == 5) chk("d3_blank_before", VGA_BLANK_N2, 0);
      if (cyc == 6) chk("d3_blank_rise", VGA_BLANK_N2, 1);
      if (cyc == 256) chk("fs_wrap", frame_start, 1);
    end
    chk("cnt_pix_req", cnt_req, 32);
    chk("cnt_hs_low", cnt_hs, 24);
    chk("cnt_vs_low", cnt_vs, 16);
    chk("cnt_blank_hi", cnt_bl, 32);
    chk("cnt_blank_hi_d3", cnt_bl2, 32);
    chk("cnt_line_start", cnt_ls, 8);
    chk("cnt_frame_start", cnt_fs, 1);

    // Freeze just after the (5,2) request; raster holds at (6,2)
    while (cyc < 331) tick();
    chk("pre_freeze_req", pix_req, 1);
    chk("pre_freeze_x", x, 5);
    chk("pre_freeze_y", y, 2);
    tick();
    chk("freeze_x_start", x, 6);
    chk("freeze_blank_before", VGA_BLANK_N, 1);
    en = 1'b0;
    #1;
    chk("freeze_blank_forced", VGA_BLANK_N, 0);
    chk("freeze_req_forced", pix_req, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("freeze_x", x, 6);
      chk("freeze_y", y, 2);
      chk("freeze_pix_req", pix_req, 0);
      chk("freeze_pix_ce", pix_ce, 0);
      chk("freeze_blank", VGA_BLANK_N, 0);
      chk("freeze_hs", VGA_HS, 1);
      chk("freeze_vga_clk", VGA_CLK, cyc % 2);
    end
    en = 1'b1;
    tick();
    chk("resume_pix_ce", pix_ce, 1);
    chk("resume_req", pix_req, 1);
    chk("resume_x", x, 6);
    chk("resume_y", y, 2);
    tick();
    chk("resume_next_x", x, 7);
    chk("resume_blank", VGA_BLANK_N, 1);

    // Asynchronous reset in the middle of line 6
    budget = 400;
    while (!(x == 10'd0 && y == 10'd6) && budget > 0) begin
      tick();
      budget--;
    end
    chk("reach_y6", (budget > 0), 1);
    chk("y6_line_start", line_start, 1);
    chk("y6_vs_low", VGA_VS, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_hs", VGA_HS, 1);
    chk("mid_rst_vs", VGA_VS, 1);
    chk("mid_rst_blank", VGA_BLANK_N, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_ls", line_start, 0);
    chk("mid_rst_vga_clk", VGA_CLK, 0);
    tick();
    tick();
    chk("mid_rst_hold_fs", frame_start, 0);
    reset = 1'b0;
    tick();
    chk("restart_req", pix_req, 1);
    chk("restart_x", x, 0);
    chk("restart_fs", frame_start, 0);
    tick();
    chk("restart_next_x", x, 1);
    chk("restart_fs2", frame_start, 0);
    chk("restart_ls", line_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator for the Proyecto2 display path.
- Derives the pixel clock from CLOCK_50 with an integer divider and runs the horizontal/vertical counters.
- Issues per-pixel requests (x, y) to the pixel source.
- Drives VGA_CLK/HS/VS/BLANK_N, delayed by a configurable number of pixel ticks so they line up with the pixel source's RGB latency.
- Generalises the fixed 640x480 timing to any resolution, sync polarity, clock ratio and pipeline depth, and adds enable/freeze and frame markers.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, asserted level of VGA_HS
VS_POL, 0, asserted level of VGA_VS
CLK_DIV, 2, CLOCK_50 cycles per pixel; even, >=2
PIPE_DELAY, 1, pixel ticks from pix_req to VGA_* outputs; >=1
X_W, 10, width of x; must hold H_TOTAL-1
Y_W, 10, width of y; must hold V_TOTAL-1

Ports:
CLOCK_50 input 1 system clock
reset input 1 asynchronous, active-high
en input 1 run enable; 0 freezes raster
pix_ce output 1 one-cycle pixel tick
pix_req output 1 pixel (x,y) requested this tick
x output X_W current horizontal counter
y output Y_W current vertical counter
frame_start output 1 one-cycle pulse at start of frame
line_start output 1 one-cycle pulse at start of each line
VGA_CLK output 1 pixel clock to DAC
VGA_HS output 1 horizontal sync, delayed
VGA_VS output 1 vertical sync, delayed
VGA_BLANK_N output 1 active-video flag, delayed

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL likewise.
- Reset (asynchronous, all registers):
  - Divider d=0, VGA_CLK=0, x=y=0.
  - pix_ce=0, pix_req=0, frame_start=0, line_start=0.
  - Delay line filled with blank/deasserted values: VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK_N=0.
- Divider:
  - d counts 0..CLK_DIV-1 and runs regardless of en.
  - VGA_CLK is registered, 1 for d in [CLK_DIV/2, CLK_DIV-1], else 0 (50% duty).
  - pix_ce = (d==CLK_DIV-1) && en.
- Counters, on pix_ce:
  - x increments; at x=H_TOTAL-1 it wraps to 0 and y increments.
  - At y=V_TOTAL-1 with x wrapping, y wraps to 0.
  - Counters therefore change on the VGA_CLK falling edge and are stable at its rising edge.
- pix_req = pix_ce && x<H_ACTIVE && y<V_ACTIVE, combinational from registered terms.
- Raw timing, per current (x,y):
  - hs_raw asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - blank_raw_n = active region.
- Delay line:
  - PIPE_DELAY-stage shift register, advanced only on pix_ce; stage 0 captures raw values of the current (x,y).
  - VGA_* outputs are the last stage, so the VGA_* value during pixel period k belongs to the (x,y) presented in period k-PIPE_DELAY.
  - Outputs are asserted at HS_POL/VS_POL levels.
- line_start: registered, high for one CLOCK_50 cycle immediately after x becomes 0.
- frame_start: registered, high for one CLOCK_50 cycle immediately after (x,y) becomes (0,0). Neither pulse fires out of reset, only on wrap.
- en=0:
  - pix_ce, pix_req and pulses are suppressed; counters and delay line hold.
  - VGA_BLANK_N is forced 0 combinationally; HS/VS hold their last value.
  - VGA_CLK keeps toggling.
  - Deassertion mid-line resumes from the held (x,y) on the next d==CLK_DIV-1.
- Reset mid-frame returns everything to reset values within the same cycle (asynchronous); the raster restarts at (0,0).
- Timing parameters must be >=1; illegal parameters are not checked.

Test Plan:
Test parameters for all scenarios: H 8/2/3/3 (H_TOTAL=16), V 4/1/1/2 (V_TOTAL=8), CLK_DIV=2, PIPE_DELAY=1, polarities 0.
1. Reset high 3 cycles, then release with en=1 -> outputs at reset values while held. After release: VGA_CLK toggles every cycle, pix_ce every 2nd cycle, first pix_req with x=0,y=0.
2. Run 256 cycles (one frame) -> 32 pix_req pulses (8x4). After the x=15 tick, line_start fires and y increments. frame_start fires once when (15,7) wraps to (0,0).
3. Check HS/VS/BLANK alignment -> VGA_HS low for exactly 3 pixel ticks, starting one tick after x=10 is presented. VGA_VS low for exactly 16 ticks, during line y=5 delayed by one tick. VGA_BLANK_N high for 8 ticks per active line.
4. Rebuild with PIPE_DELAY=3 -> VGA_BLANK_N rise lags the x=0 pix_req by exactly 3 pixel ticks (6 cycles).
5. Drop en for 10 cycles at x=5,y=2 -> x/y hold, pix_req=0, VGA_BLANK_N=0, VGA_CLK still toggles. On re-enable, the next pix_req is x=6,y=2.
6. Assert reset mid-frame at y=6 -> same cycle x=y=0, VGA_HS=VGA_VS=1, VGA_BLANK_N=0, no frame_start pulse.
